uart_tx_fifo: RTL

Buffered RS-232 transmitter: bytes written by the core land in a FIFO and are serialized back-to-back onto the TxD line without core stalls. It is the outbound counterpart of the serial receive path. It sits between the processor's memory-mapped UART register and the board TxD pin. Frame is 8N1/8N2 with optional parity, LSB first.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_sync_fifo.sv | 70 +++++++
 rtl/uart_tx_fifo.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: line-state encoding, baud divisor
// and parity-mode constants for the transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Rounded clocks per bit
  function automatic int calc_div(
    input int clk_freq,
    input int baud
  );
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous circular FIFO, registered full/empty/count,
// one-cycle overflow pulse on a write attempt while full.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_count;
  logic             r_full;
  logic             r_empty;
  logic             r_ovf;

  logic             w_push;
  logic             w_pop;
  logic [PW-1:0]    w_wr_nxt;
  logic [PW-1:0]    w_rd_nxt;
  logic [PW-1:0]    w_cnt_nxt;

  assign w_push    = i_wr_en && !r_full;
  assign w_pop     = i_rd_en && !r_empty;
  assign w_wr_nxt  = r_wr_ptr + PW'(w_push);
  assign w_rd_nxt  = r_rd_ptr + PW'(w_pop);
  assign w_cnt_nxt = w_wr_nxt - w_rd_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_ovf    <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_cnt_nxt;
      r_full   <= (w_cnt_nxt == PW'(DEPTH));
      r_empty  <= (w_cnt_nxt == '0);
      r_ovf    <= i_wr_en && r_full;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

  assign o_rd_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_full     = r_full;
  assign o_empty    = r_empty;
  assign o_count    = r_count;
  assign o_overflow = r_ovf;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8-bit serial transmitter: FIFO-fed frame FSM
// with baud divider, optional parity, 1 or 2 stop bits.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 2,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_done
);

  localparam int   DIV       = calc_div(CLK_FREQ, BAUD);
  localparam int   BW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic STOP_LAST = (STOP_BITS == 2);
  localparam logic PAR_MODE  = (PARITY_ODD != 0) ? PAR_ODD
                                                  : PAR_EVEN;

  uart_state_e r_state, w_state_nxt;
  logic [BW-1:0] r_cnt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic          r_stop, w_stop_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_par, w_par_nxt;
  logic          r_tx, w_tx_nxt;
  logic          r_done, w_done_nxt;

  logic          w_pop;
  logic          w_empty;
  logic [7:0]    w_rd_data;
  logic          w_bit_end;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr_en    (wr_en),
    .i_wr_data  (wr_data),
    .i_rd_en    (w_pop),
    .o_rd_data  (w_rd_data),
    .o_full     (full),
    .o_empty    (w_empty),
    .o_count    (count),
    .o_overflow (overflow)
  );

  assign w_bit_end = (r_state != IDLE) &&
                     (r_cnt == BW'(DIV - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit;
    w_stop_nxt  = r_stop;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_pop       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_rd_data;
          w_par_nxt   = 1'b0;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_bit_nxt   = 3'd0;
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = {1'b0, r_shift[7:1]};
          w_par_nxt   = r_par ^ r_shift[0];
          w_bit_nxt   = r_bit + 3'd1;
          w_stop_nxt  = 1'b0;
          if (r_bit == 3'd7)
            w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (w_bit_end) begin
          w_stop_nxt  = 1'b0;
          w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          if (r_stop == STOP_LAST) begin
            // Back-to-back frames: skip IDLE when data waits
            if (!w_empty) begin
              w_pop       = 1'b1;
              w_shift_nxt = w_rd_data;
              w_par_nxt   = 1'b0;
              w_state_nxt = START;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_stop_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_tx_nxt = 1'b1;
    unique case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_shift_nxt[0];
      PARITY:  w_tx_nxt = w_par_nxt ^ PAR_MODE;
      default: w_tx_nxt = 1'b1;
    endcase
  end

  // Registered so the pulse sits in the frame's final clock
  assign w_done_nxt = (r_state == STOP) &&
                      (r_stop == STOP_LAST) &&
                      (r_cnt == BW'(DIV - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= 3'd0;
      r_stop  <= 1'b0;
      r_shift <= 8'h00;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bit   <= w_bit_nxt;
      r_stop  <= w_stop_nxt;
      r_shift <= w_shift_nxt;
      r_par   <= w_par_nxt;
      r_tx    <= w_tx_nxt;
      r_done  <= w_done_nxt;
      if (r_state == IDLE || w_bit_end)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + BW'(1);
    end
  end

  assign empty   = w_empty;
  assign tx      = r_tx;
  assign tx_busy = (r_state != IDLE);
  assign tx_done = r_done;

endmodule
